// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle instruction sequencer for the MIPS datapath.
// Walks fetch / decode / per-class execute states, waits on MOC with a
// bounded timeout that traps, latches the ALU function at decode and counts
// retired instructions. All outputs are registered.
module control_sequencer #(
  parameter int STATE_W   = 7,
  parameter int TIMEOUT_W = 4,
  parameter int CNT_W     = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [31:0]        Instruction,
  input  logic               MOC,
  input  logic               Cond,
  output logic [STATE_W-1:0] State,
  output logic [3:0]         Alu_Sel,
  output logic               Mem_Req,
  output logic               Mem_Wr,
  output logic               Retire,
  output logic               Trap,
  output logic [CNT_W-1:0]   Instr_Count
);

  typedef enum logic [3:0] {
    S_RESET      = 4'd0,
    S_FETCH_ADDR = 4'd1,
    S_FETCH_WAIT = 4'd2,
    S_IR_LOAD    = 4'd3,
    S_DECODE     = 4'd4,
    S_ALU_R      = 4'd5,
    S_ALU_I      = 4'd6,
    S_LD_ADDR    = 4'd7,
    S_LD_WAIT    = 4'd8,
    S_LD_WB      = 4'd9,
    S_ST_ADDR    = 4'd10,
    S_ST_WAIT    = 4'd11,
    S_BR_EVAL    = 4'd12,
    S_BR_TAKE    = 4'd13,
    S_JUMP       = 4'd14,
    S_TRAP       = 4'd15
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_LUI  = 4'd8;

  // Wait limit L = 2^TIMEOUT_W - 1: the all-ones counter value.
  localparam logic [TIMEOUT_W-1:0] WAIT_LIMIT = {TIMEOUT_W{1'b1}};
  localparam logic [TIMEOUT_W-1:0] WAIT_ONE   = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]     CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [3:0]           alu_sel_q, alu_sel_d;
  logic [TIMEOUT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 retire_q, retire_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_wr_q, mem_wr_d;
  logic                 trap_q, trap_d;

  state_t               dec_state_s;
  logic [3:0]           dec_alu_s;
  state_t               wait_exit_s;
  logic                 unused_instr_s;

  // Only opcode and funct fields steer the sequencer.
  assign unused_instr_s = ^Instruction[25:6];

  // Instruction decoder: class entry state and ALU function for the IR.
  always_comb begin
    dec_state_s = S_TRAP;
    dec_alu_s   = ALU_ADD;
    case (Instruction[31:26])
      6'b000000: begin
        dec_state_s = S_ALU_R;
        case (Instruction[5:0])
          6'b100001: dec_alu_s = ALU_ADD;
          6'b100011: dec_alu_s = ALU_SUB;
          6'b100100: dec_alu_s = ALU_AND;
          6'b100101: dec_alu_s = ALU_OR;
          6'b100110: dec_alu_s = ALU_XOR;
          6'b100111: dec_alu_s = ALU_NOR;
          6'b101011: dec_alu_s = ALU_SLTU;
          6'b000000: dec_alu_s = ALU_SLL;
          default: begin
            dec_state_s = S_TRAP;
            dec_alu_s   = ALU_ADD;
          end
        endcase
      end
      6'b001001: begin dec_state_s = S_ALU_I;   dec_alu_s = ALU_ADD;  end
      6'b001011: begin dec_state_s = S_ALU_I;   dec_alu_s = ALU_SLTU; end
      6'b001100: begin dec_state_s = S_ALU_I;   dec_alu_s = ALU_AND;  end
      6'b001101: begin dec_state_s = S_ALU_I;   dec_alu_s = ALU_OR;   end
      6'b001110: begin dec_state_s = S_ALU_I;   dec_alu_s = ALU_XOR;  end
      6'b001111: begin dec_state_s = S_ALU_I;   dec_alu_s = ALU_LUI;  end
      6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101: begin
        dec_state_s = S_LD_ADDR;
        dec_alu_s   = ALU_ADD;
      end
      6'b101000, 6'b101001, 6'b101011: begin
        dec_state_s = S_ST_ADDR;
        dec_alu_s   = ALU_ADD;
      end
      6'b000100, 6'b000101: begin dec_state_s = S_BR_EVAL; dec_alu_s = ALU_SUB; end
      6'b000010, 6'b000011: begin dec_state_s = S_JUMP;    dec_alu_s = ALU_ADD; end
      default: begin
        dec_state_s = S_TRAP;
        dec_alu_s   = ALU_ADD;
      end
    endcase
  end

  // Where each MOC wait state goes once memory completes.
  always_comb begin
    case (state_q)
      S_FETCH_WAIT: wait_exit_s = S_IR_LOAD;
      S_LD_WAIT:    wait_exit_s = S_LD_WB;
      default:      wait_exit_s = S_FETCH_ADDR;
    endcase
  end

  // Next-state, wait timeout, retire and registered-output decode.
  always_comb begin
    state_d    = state_q;
    alu_sel_d  = alu_sel_q;
    wait_cnt_d = {TIMEOUT_W{1'b0}};  // cleared whenever not counting, so entry starts at 0
    retire_d   = 1'b0;
    case (state_q)
      S_RESET:      state_d = S_FETCH_ADDR;
      S_FETCH_ADDR: state_d = S_FETCH_WAIT;
      S_IR_LOAD:    state_d = S_DECODE;
      S_DECODE: begin
        state_d   = dec_state_s;
        alu_sel_d = dec_alu_s;
      end
      S_ALU_R, S_ALU_I, S_LD_WB, S_BR_TAKE, S_JUMP: begin
        state_d  = S_FETCH_ADDR;
        retire_d = 1'b1;
      end
      S_LD_ADDR: state_d = S_LD_WAIT;
      S_ST_ADDR: state_d = S_ST_WAIT;
      S_FETCH_WAIT, S_LD_WAIT, S_ST_WAIT: begin
        if (MOC) begin
          state_d  = wait_exit_s;
          retire_d = (state_q == S_ST_WAIT);
        end else if (wait_cnt_q == WAIT_LIMIT) begin
          state_d = S_TRAP;
        end else begin
          state_d    = state_q;
          wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end
      end
      S_BR_EVAL: begin
        if (Cond) begin
          state_d = S_BR_TAKE;
        end else begin
          state_d  = S_FETCH_ADDR;
          retire_d = 1'b1;
        end
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase

    if (retire_d) begin
      count_d = count_q + CNT_ONE;
    end else begin
      count_d = count_q;
    end

    // Outputs follow the next state so they are flops aligned with State.
    mem_req_d = (state_d == S_FETCH_WAIT) || (state_d == S_LD_WAIT) ||
                (state_d == S_ST_WAIT);
    mem_wr_d  = (state_d == S_ST_WAIT);
    trap_d    = (state_d == S_TRAP);
  end

  // State and output registers, cleared asynchronously by Reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_RESET;
      alu_sel_q  <= ALU_ADD;
      wait_cnt_q <= {TIMEOUT_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      retire_q   <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_wr_q   <= 1'b0;
      trap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_sel_q  <= alu_sel_d;
      wait_cnt_q <= wait_cnt_d;
      count_q    <= count_d;
      retire_q   <= retire_d;
      mem_req_q  <= mem_req_d;
      mem_wr_q   <= mem_wr_d;
      trap_q     <= trap_d;
    end
  end

  assign State       = STATE_W'(state_q);
  assign Alu_Sel     = alu_sel_q;
  assign Mem_Req     = mem_req_q;
  assign Mem_Wr      = mem_wr_q;
  assign Retire      = retire_q;
  assign Trap        = trap_q;
  assign Instr_Count = count_q;

endmodule
